// File: rtl/imm_encode.sv
// imm_encode: packs instruction format, register/function fields and an immediate into a
// 32-bit RV64 instruction word via a 2-stage valid/ready pipeline. Macro IMM_ENCODE_CHECK_EN enables range checking.
`ifndef WIDTH
`define WIDTH 64
`endif

module imm_encode (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [`WIDTH-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHIFT = 3'd6,
        FMT_RSVD  = 3'd7
    } fmt_e;

    logic        w_s1_adv;
    logic        w_s2_adv;
    logic        r_s1_valid;
    logic        r_s2_valid;
    fmt_e        r_s1_fmt;
    logic [6:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_funct3;
    logic [6:0]  r_s1_funct7;
    logic [31:0] r_s1_imm;
    logic [31:0] w_packed;
    logic [31:0] r_s2_instr;

    // Each stage moves whenever the stage ahead of it is empty or moving, so bubbles collapse.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

`ifdef IMM_ENCODE_CHECK_EN
    logic       w_in_err;
    logic       r_s1_err;
    logic       r_s2_err;
    logic [7:0] r_err_cnt;

    // Violation means the immediate is not the sign extension of the bits the format can hold.
    always_comb begin
        w_in_err = 1'b0;
        case (fmt_e'(in_fmt))
            FMT_R:        w_in_err = 1'b0;
            FMT_I, FMT_S: w_in_err = (in_imm != {{(`WIDTH-12){in_imm[11]}}, in_imm[11:0]});
            FMT_B:        w_in_err = (in_imm != {{(`WIDTH-13){in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
            FMT_U:        w_in_err = (in_imm[11:0] != 12'h000) ||
                                     (in_imm != {{(`WIDTH-32){in_imm[31]}}, in_imm[31:0]});
            FMT_J:        w_in_err = (in_imm != {{(`WIDTH-21){in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
            FMT_SHIFT:    w_in_err = |in_imm[`WIDTH-1:6];
            default:      w_in_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (r_s2_valid && out_ready && r_s2_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign out_err = r_s2_err;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_imm;

    // Only the low 32 immediate bits are ever packed; the rest matter only to the range check.
    assign w_unused_imm = ^in_imm[`WIDTH-1:32];
    assign out_err      = 1'b0;
    assign err_cnt      = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= FMT_R;
            r_s1_opcode <= 7'h00;
            r_s1_rd     <= 5'h00;
            r_s1_rs1    <= 5'h00;
            r_s1_rs2    <= 5'h00;
            r_s1_funct3 <= 3'h0;
            r_s1_funct7 <= 7'h00;
            r_s1_imm    <= 32'h0;
`ifdef IMM_ENCODE_CHECK_EN
            r_s1_err    <= 1'b0;
`endif
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fmt    <= fmt_e'(in_fmt);
                r_s1_opcode <= in_opcode;
                r_s1_rd     <= in_rd;
                r_s1_rs1    <= in_rs1;
                r_s1_rs2    <= in_rs2;
                r_s1_funct3 <= in_funct3;
                r_s1_funct7 <= in_funct7;
                r_s1_imm    <= in_imm[31:0];
`ifdef IMM_ENCODE_CHECK_EN
                r_s1_err    <= w_in_err;
`endif
            end
        end
    end

    // Out-of-range immediates are still packed from their truncated low bits.
    always_comb begin
        w_packed = 32'h0;
        case (r_s1_fmt)
            FMT_R:     w_packed = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_I:     w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_S:     w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                   r_s1_imm[4:0], r_s1_opcode};
            FMT_B:     w_packed = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                   r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
            FMT_U:     w_packed = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
            FMT_J:     w_packed = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                                   r_s1_rd, r_s1_opcode};
            FMT_SHIFT: w_packed = {r_s1_funct7[6:1], r_s1_imm[5:0], r_s1_rs1, r_s1_funct3,
                                   r_s1_rd, r_s1_opcode};
            default:   w_packed = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= 32'h0;
`ifdef IMM_ENCODE_CHECK_EN
            r_s2_err   <= 1'b0;
`endif
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr <= w_packed;
`ifdef IMM_ENCODE_CHECK_EN
                r_s2_err   <= r_s1_err;
`endif
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: directed vectors, randomized traffic against a
// decode-side reference model, backpressure, counter saturation and mid-run reset.
`timescale 1ns/1ps

module tb_imm_encode;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [63:0] imm;
    } req_t;

`ifdef IMM_ENCODE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_cnt;

    int   checks;
    int   errors;
    int   exp_cnt;
    req_t q[$];

    imm_encode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint wrap_mod(input longint v, input longint m);
        longint r;
        r = v % m;
        if (r < 0) r = r + m;
        return r;
    endfunction

    function automatic longint fold_signed(input longint v, input longint m);
        longint r;
        r = wrap_mod(v, m);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    // Immediate value the packed word is expected to carry after truncation to the format.
    function automatic longint exp_imm(input req_t r);
        longint s;
        longint t;
        s = longint'(r.imm);
        case (r.fmt)
            3'd1, 3'd2: return fold_signed(s, 4096);
            3'd3: begin t = wrap_mod(s, 8192); t = t - (t % 2); return fold_signed(t, 8192); end
            3'd4: begin
                t = wrap_mod(s, 64'sd4294967296);
                t = t - (t % 4096);
                return fold_signed(t, 64'sd4294967296);
            end
            3'd5: begin t = wrap_mod(s, 2097152); t = t - (t % 2); return fold_signed(t, 2097152); end
            3'd6: return longint'(r.imm % 64);
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_err(input req_t r);
        longint s;
        s = longint'(r.imm);
        if (!CHK) return 1'b0;
        case (r.fmt)
            3'd0: return 1'b0;
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3: return (s < -4096) || (s > 4095) || (s % 2 != 0);
            3'd4: return (s % 4096 != 0) || (s < -64'sd2147483648) || (s > 64'sd2147483647);
            3'd5: return (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            3'd6: return r.imm >= 64'd64;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit has_rd(input logic [2:0] f);  return f inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6}; endfunction
    function automatic bit has_rs1(input logic [2:0] f); return f inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6}; endfunction
    function automatic bit has_rs2(input logic [2:0] f); return f inside {3'd0, 3'd2, 3'd3}; endfunction

    // Expected decoded view: {imm, opcode, rd, rs1, rs2, funct3, funct7-bits}; absent fields are 0.
    function automatic logic [95:0] exp_sig(input req_t r);
        logic [6:0] f7;
        if (r.fmt == 3'd7) return 96'h0;
        f7 = (r.fmt == 3'd0) ? r.funct7 : (r.fmt == 3'd6) ? {r.funct7[6:1], 1'b0} : 7'h0;
        return {exp_imm(r), r.opcode,
                has_rd(r.fmt) ? r.rd : 5'd0, has_rs1(r.fmt) ? r.rs1 : 5'd0,
                has_rs2(r.fmt) ? r.rs2 : 5'd0, has_rs1(r.fmt) ? r.funct3 : 3'd0, f7};
    endfunction

    // Standard RISC-V decode of a word into the same view.
    function automatic logic [95:0] act_sig(input logic [2:0] f, input logic [31:0] w);
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        logic signed [31:0] s32;
        longint             im;
        logic [6:0]         f7;
        if (f == 3'd7) return {32'h0, w, 32'h0};
        im = 0;
        case (f)
            3'd1: begin s12 = w[31:20]; im = s12; end
            3'd2: begin s12 = {w[31:25], w[11:7]}; im = s12; end
            3'd3: begin s13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; im = s13; end
            3'd4: begin s32 = {w[31:12], 12'h000}; im = s32; end
            3'd5: begin s21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; im = s21; end
            3'd6: im = longint'(w[25:20]);
            default: im = 0;
        endcase
        f7 = (f == 3'd0) ? w[31:25] : (f == 3'd6) ? {w[31:26], 1'b0} : 7'h0;
        return {im, w[6:0],
                has_rd(f) ? w[11:7] : 5'd0, has_rs1(f) ? w[19:15] : 5'd0,
                has_rs2(f) ? w[24:20] : 5'd0, has_rs1(f) ? w[14:12] : 3'd0, f7};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic req_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [63:0] imm);
        req_t r;
        r.fmt = f; r.opcode = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.funct3 = f3; r.funct7 = f7; r.imm = imm;
        return r;
    endfunction

    function automatic logic [63:0] rand_imm();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'({$urandom, $urandom});
            1: v = longint'($urandom_range(0, 8191)) - 4096;
            2: v = longint'($urandom_range(0, 4194303)) - 2097152;
            default: begin
                case ($urandom_range(0, 15))
                    0: v = 2047;      1: v = 2048;      2: v = -2048;    3: v = -2049;
                    4: v = 4094;      5: v = 4096;      6: v = -4096;    7: v = -4098;
                    8: v = 1048574;   9: v = 1048576;   10: v = -1048576;
                    11: v = 64'sd2147479552;            12: v = -64'sd2147483648;
                    13: v = 64'sd2147483648;            14: v = 63;
                    default: v = 64;
                endcase
            end
        endcase
        return v;
    endfunction

    function automatic req_t rand_req();
        return mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
    endfunction

    // One clock cycle: drive at the falling edge, sample just after, return at the rising edge.
    task automatic step(input req_t r, input bit v, input bit ordy, output bit acc, output bit xfer,
                        output bit ov, output logic [31:0] w, output logic e);
        @(negedge clk);
        in_valid  = v;
        in_fmt    = r.fmt;
        in_opcode = r.opcode;
        in_rd     = r.rd;
        in_rs1    = r.rs1;
        in_rs2    = r.rs2;
        in_funct3 = r.funct3;
        in_funct7 = r.funct7;
        in_imm    = r.imm;
        out_ready = ordy;
        #1;
        acc  = in_valid && in_ready;
        ov   = out_valid;
        xfer = out_valid && out_ready;
        w    = out_instr;
        e    = out_err;
        @(posedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %08h want 00000000", out_instr); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %0b want 0", out_err); end
        if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        $display("reset: out_valid=%0b in_ready=%0b err_cnt=%0d", out_valid, in_ready, err_cnt);
    endtask

    task automatic test_directed();
        req_t        v[8];
        logic [31:0] ew[8];
        bit          ee[8];
        req_t        idle;
        bit          acc, xfer, ov;
        logic [31:0] w;
        logic        e;
        v[0] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        v[1] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, -64'sd4);
        v[2] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, -64'sd3);
        v[3] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 64'hFFFF_FFFF_8000_0000);
        v[4] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 64'h0000_0000_8000_0000);
        v[5] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 64'd2048);
        v[6] = mk(3'd6, 7'h13, 5'd3, 5'd3, 5'd0, 3'd1, 7'h0, 64'd63);
        v[7] = mk(3'd6, 7'h13, 5'd3, 5'd3, 5'd0, 3'd1, 7'h0, 64'd64);
        ew = '{32'hFFF00093, 32'hFE208EE3, 32'hFE208EE3, 32'h800002B7,
               32'h800002B7, 32'h001000EF, 32'h03F19193, 32'h00019193};
        ee = '{1'b0, 1'b0, CHK, 1'b0, CHK, 1'b0, 1'b0, CHK};
        idle = mk(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 64'h0);
        for (int i = 0; i < 8; i++) begin
            step(v[i], 1'b1, 1'b1, acc, xfer, ov, w, e);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got %0b want 1", i, acc); end
            step(idle, 1'b0, 1'b1, acc, xfer, ov, w, e);
            checks++;
            if (ov !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %0b want 0", i, ov); end
            step(idle, 1'b0, 1'b1, acc, xfer, ov, w, e);
            checks += 3;
            if (ov !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got %0b want 1", i, ov); end
            if (w !== ew[i]) begin errors++; $display("FAIL dir%0d_instr got %08h want %08h", i, w, ew[i]); end
            if (e !== ee[i]) begin errors++; $display("FAIL dir%0d_err got %0b want %0b", i, e, ee[i]); end
            if (xfer && ee[i] && exp_cnt < 255) exp_cnt++;
            #1;
            checks++;
            if (err_cnt !== 8'(exp_cnt)) begin
                errors++; $display("FAIL dir%0d_err_cnt got %0d want %0d", i, err_cnt, exp_cnt);
            end
            $display("directed %0d: fmt=%0d instr=%08h err=%0b err_cnt=%0d", i, v[i].fmt, w, e, err_cnt);
        end
    endtask

    task automatic test_random();
        req_t        cur, exp;
        req_t        idle;
        bit          have, ordy, acc, xfer, ov, stalled;
        logic [31:0] w, pw;
        logic        e, pe;
        int          n;
        have = 1'b0; stalled = 1'b0; pw = 32'h0; pe = 1'b0; n = 0;
        idle = mk(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 64'h0);
        cur  = idle;
        for (int c = 0; c < 460; c++) begin
            if (c < 400 && !have && $urandom_range(0, 3) != 0) begin cur = rand_req(); have = 1'b1; end
            ordy = (c >= 400) || ($urandom_range(0, 3) != 0);
            step(cur, have, ordy, acc, xfer, ov, w, e);
            if (stalled) begin
                checks++;
                if (ov !== 1'b1 || w !== pw || e !== pe) begin
                    errors++;
                    $display("FAIL rand_hold got v=%0b %08h/%0b want v=1 %08h/%0b", ov, w, e, pw, pe);
                end
            end
            stalled = ov && !ordy;
            pw = w; pe = e;
            if (xfer) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious got %08h want no output", w);
                end else begin
                    exp = q.pop_front();
                    checks++;
                    if (act_sig(exp.fmt, w) !== exp_sig(exp)) begin
                        errors++;
                        $display("FAIL rand_instr fmt=%0d imm=%016h got %08h (%024h) want %024h",
                                 exp.fmt, exp.imm, w, act_sig(exp.fmt, w), exp_sig(exp));
                    end
                    if (e !== exp_err(exp)) begin
                        errors++;
                        $display("FAIL rand_err fmt=%0d imm=%016h got %0b want %0b", exp.fmt, exp.imm, e, exp_err(exp));
                    end
                    if (exp_err(exp) && exp_cnt < 255) exp_cnt++;
                    n++;
                    $display("random xfer %0d: fmt=%0d imm=%016h instr=%08h err=%0b", n, exp.fmt, exp.imm, w, e);
                end
            end
            if (acc) begin q.push_back(cur); have = 1'b0; end
        end
        checks += 2;
        if (q.size() != 0 || have) begin errors++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
        if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rand_err_cnt got %0d want %0d", err_cnt, exp_cnt); end
        q.delete();
    endtask

    task automatic test_back_to_back_backpressure();
        req_t        r[4];
        req_t        exp;
        bit          acc, xfer, ov;
        logic [31:0] w, hold_w;
        logic        e, hold_e;
        int          idx, got, cyc;
        for (int i = 0; i < 4; i++) r[i] = rand_req();
        idx = 0; hold_w = 32'h0; hold_e = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(r[idx], 1'b1, 1'b0, acc, xfer, ov, w, e);
            checks++;
            if (acc !== (c < 2)) begin errors++; $display("FAIL bp_accept cycle%0d got %0b want %0b", c, acc, c < 2); end
            if (c == 2) begin hold_w = w; hold_e = e; end
            if (c == 3) begin
                checks++;
                if (ov !== 1'b1 || w !== hold_w || e !== hold_e) begin
                    errors++;
                    $display("FAIL bp_hold got v=%0b %08h/%0b want v=1 %08h/%0b", ov, w, e, hold_w, hold_e);
                end
            end
            if (acc) begin q.push_back(r[idx]); idx++; end
            $display("backpressure stall %0d: accept=%0b out_valid=%0b instr=%08h", c, acc, ov, w);
        end
        got = 0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            step(r[idx < 4 ? idx : 3], idx < 4, 1'b1, acc, xfer, ov, w, e);
            if (xfer) begin
                exp = q.pop_front();
                checks += 2;
                if (act_sig(exp.fmt, w) !== exp_sig(exp)) begin
                    errors++;
                    $display("FAIL bp_order%0d got %024h want %024h", got, act_sig(exp.fmt, w), exp_sig(exp));
                end
                if (e !== exp_err(exp)) begin errors++; $display("FAIL bp_err%0d got %0b want %0b", got, e, exp_err(exp)); end
                if (exp_err(exp) && exp_cnt < 255) exp_cnt++;
                got++;
                $display("backpressure xfer %0d: instr=%08h err=%0b", got, w, e);
            end
            if (acc) begin q.push_back(r[idx]); idx++; end
            cyc++;
        end
        checks++;
        if (got != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got); end
        step(r[0], 1'b0, 1'b1, acc, xfer, ov, w, e);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL bp_duplicate got out_valid=%0b want 0", ov); end
        q.delete();
    endtask

    task automatic test_saturation();
        req_t        r;
        bit          acc, xfer, ov;
        logic [31:0] w;
        logic        e;
        int          sent, recv, cyc;
        r = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'h0, 64'h0);
        sent = 0; recv = 0; cyc = 0;
        while (recv < 300 && cyc < 400) begin
            step(r, sent < 300, 1'b1, acc, xfer, ov, w, e);
            if (acc) sent++;
            if (xfer) begin
                checks++;
                if (w !== 32'h0 || e !== CHK) begin
                    errors++; $display("FAIL sat_word%0d got %08h/%0b want 00000000/%0b", recv, w, e, CHK);
                end
                if (CHK && exp_cnt < 255) exp_cnt++;
                recv++;
            end
            cyc++;
        end
        #1;
        checks += 2;
        if (recv != 300) begin errors++; $display("FAIL sat_count got %0d want 300", recv); end
        if (err_cnt !== (CHK ? 8'hFF : 8'h00)) begin
            errors++; $display("FAIL sat_err_cnt got %0d want %0d", err_cnt, CHK ? 255 : 0);
        end
        $display("saturation: transfers=%0d err_cnt=%0d", recv, err_cnt);
    endtask

    task automatic test_reset_mid();
        req_t        r;
        bit          acc, xfer, ov;
        logic [31:0] w;
        logic        e;
        int          seen;
        r = mk(3'd7, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h0, 64'h0);
        for (int i = 0; i < 2; i++) begin
            step(r, 1'b1, 1'b0, acc, xfer, ov, w, e);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL rstmid_accept%0d got %0b want 1", i, acc); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %0b want 0", out_valid); end
        if (err_cnt !== 8'h00) begin errors++; $display("FAIL rstmid_err_cnt got %0d want 0", err_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
        exp_cnt = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(r, 1'b0, 1'b1, acc, xfer, ov, w, e);
            if (ov) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_leak got %0d words want 0", seen); end
        $display("reset mid-run: out_valid=%0b err_cnt=%0d leaked=%0d", out_valid, err_cnt, seen);
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_fmt = 3'd0; in_opcode = 7'h0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'h0; in_imm = 64'h0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back_backpressure();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
